// File: rtl/display_frame_arbiter.sv
// display_frame_arbiter
//
// Shares the 4-digit 7-segment display between two requesters (A and B).
// Each requester offers a 16-bit hex value plus a 4-bit decimal-point mask
// over a valid/ready handshake. Grants are round-robin; the winner's nibbles
// are converted to segment bytes and held in frame registers that drive the
// display controller's digit inputs. After each frame load the winner keeps
// ownership for HOLD_CYCLES cycles so the two sources cannot flicker.
//
// Compile-time option:
//   LEADING_ZERO_BLANK_EN - when defined, digits above the most significant
//                           nonzero nibble have segments a-g dark (DP still
//                           shown); D0 is always drawn.
//
// Parameters:
//   HOLD_CYCLES - ownership window in i_clk cycles after a frame load (0 = none)
//   HOLD_WIDTH  - hold counter width, HOLD_CYCLES < 2**HOLD_WIDTH
//
// Ports:
//   i_clk, i_reset_n          clock, synchronous active-low reset
//   i_req_a_valid/value/dots  requester A frame offer
//   o_req_a_ready             A frame accepted this cycle
//   i_req_b_valid/value/dots  requester B frame offer
//   o_req_b_ready             B frame accepted this cycle
//   o_display_D0..D3          segment bytes {a,b,c,d,e,f,g,DP}, 1 = lit
//   o_owner                   00 none, 01 A, 10 B
//   o_frame_update            one-cycle pulse when the frame registers change
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no owner; arbitrate pending requests
// ACCEPT  | grantee's ready is high; capture its frame if still valid
// HOLD    | owner keeps the display; only the owner may reload it

module display_frame_arbiter #(
    parameter int HOLD_CYCLES = 1000,
    parameter int HOLD_WIDTH  = 10
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req_a_valid,
    input  logic [15:0] i_req_a_value,
    input  logic [3:0]  i_req_a_dots,
    output logic        o_req_a_ready,
    input  logic        i_req_b_valid,
    input  logic [15:0] i_req_b_value,
    input  logic [3:0]  i_req_b_dots,
    output logic        o_req_b_ready,
    output logic [7:0]  o_display_D0,
    output logic [7:0]  o_display_D1,
    output logic [7:0]  o_display_D2,
    output logic [7:0]  o_display_D3,
    output logic [1:0]  o_owner,
    output logic        o_frame_update
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_A    = 2'b01;
    localparam logic [1:0] OWN_B    = 2'b10;

    localparam int HOLD_LOAD_INT = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam logic [HOLD_WIDTH-1:0] HOLD_LOAD = HOLD_LOAD_INT[HOLD_WIDTH-1:0];

    state_t                r_state;
    logic [HOLD_WIDTH-1:0] r_hold_cnt;
    logic                  r_ptr_b;     // 1: B wins the next tie
    logic                  r_grant_b;   // 1: current grantee/owner is B
    logic                  r_ready_a;
    logic                  r_ready_b;
    logic [1:0]            r_owner;
    logic                  r_frame_update;
    logic [7:0]            r_disp_d0;
    logic [7:0]            r_disp_d1;
    logic [7:0]            r_disp_d2;
    logic [7:0]            r_disp_d3;

    state_t                w_next_state;
    logic [HOLD_WIDTH-1:0] w_next_hold_cnt;
    logic                  w_next_ptr_b;
    logic                  w_next_grant_b;
    logic                  w_next_ready_a;
    logic                  w_next_ready_b;
    logic [1:0]            w_next_owner;
    logic                  w_next_update;
    logic                  w_load;

    logic                  w_sel_valid;
    logic [15:0]           w_sel_value;
    logic [3:0]            w_sel_dots;
    logic [3:1]            w_blank;
    logic [7:0]            w_conv_d0;
    logic [7:0]            w_conv_d1;
    logic [7:0]            w_conv_d2;
    logic [7:0]            w_conv_d3;

    function automatic logic [7:0] seg_encode(input logic [3:0] nib,
                                              input logic       dp,
                                              input logic       blank);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1111110;
            4'h1:    seg = 7'b0110000;
            4'h2:    seg = 7'b1101101;
            4'h3:    seg = 7'b1111001;
            4'h4:    seg = 7'b0110011;
            4'h5:    seg = 7'b1011011;
            4'h6:    seg = 7'b1011111;
            4'h7:    seg = 7'b1110000;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1111011;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b0011111;
            4'hC:    seg = 7'b1001110;
            4'hD:    seg = 7'b0111101;
            4'hE:    seg = 7'b1001111;
            4'hF:    seg = 7'b1000111;
            default: seg = 7'b0000000;
        endcase
        if (blank) begin
            seg = 7'b0000000;
        end
        return {seg, dp};
    endfunction

    // The grantee in ACCEPT and the owner in HOLD are the same requester,
    // so one selection serves both the capture path and the owner-reload check.
    assign w_sel_valid = r_grant_b ? i_req_b_valid : i_req_a_valid;
    assign w_sel_value = r_grant_b ? i_req_b_value : i_req_a_value;
    assign w_sel_dots  = r_grant_b ? i_req_b_dots  : i_req_a_dots;

`ifdef LEADING_ZERO_BLANK_EN
    assign w_blank[3] = (w_sel_value[15:12] == 4'h0);
    assign w_blank[2] = (w_sel_value[15:8]  == 8'h00);
    assign w_blank[1] = (w_sel_value[15:4]  == 12'h000);
`else
    assign w_blank[3:1] = 3'b000;
`endif

    assign w_conv_d0 = seg_encode(w_sel_value[3:0],   w_sel_dots[0], 1'b0);
    assign w_conv_d1 = seg_encode(w_sel_value[7:4],   w_sel_dots[1], w_blank[1]);
    assign w_conv_d2 = seg_encode(w_sel_value[11:8],  w_sel_dots[2], w_blank[2]);
    assign w_conv_d3 = seg_encode(w_sel_value[15:12], w_sel_dots[3], w_blank[3]);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state        <= ST_IDLE;
            r_hold_cnt     <= '0;
            r_ptr_b        <= 1'b0;
            r_grant_b      <= 1'b0;
            r_ready_a      <= 1'b0;
            r_ready_b      <= 1'b0;
            r_owner        <= OWN_NONE;
            r_frame_update <= 1'b0;
            r_disp_d0      <= 8'h00;
            r_disp_d1      <= 8'h00;
            r_disp_d2      <= 8'h00;
            r_disp_d3      <= 8'h00;
        end else begin
            r_state        <= w_next_state;
            r_hold_cnt     <= w_next_hold_cnt;
            r_ptr_b        <= w_next_ptr_b;
            r_grant_b      <= w_next_grant_b;
            r_ready_a      <= w_next_ready_a;
            r_ready_b      <= w_next_ready_b;
            r_owner        <= w_next_owner;
            r_frame_update <= w_next_update;
            if (w_load) begin
                r_disp_d0 <= w_conv_d0;
                r_disp_d1 <= w_conv_d1;
                r_disp_d2 <= w_conv_d2;
                r_disp_d3 <= w_conv_d3;
            end
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_hold_cnt = r_hold_cnt;
        w_next_ptr_b    = r_ptr_b;
        w_next_grant_b  = r_grant_b;
        w_next_ready_a  = 1'b0;
        w_next_ready_b  = 1'b0;
        w_next_owner    = r_owner;
        w_next_update   = 1'b0;
        w_load          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_next_owner = OWN_NONE;
                if (i_req_a_valid && (!i_req_b_valid || !r_ptr_b)) begin
                    w_next_state   = ST_ACCEPT;
                    w_next_grant_b = 1'b0;
                    w_next_ready_a = 1'b1;
                    w_next_owner   = OWN_A;
                end else if (i_req_b_valid) begin
                    w_next_state   = ST_ACCEPT;
                    w_next_grant_b = 1'b1;
                    w_next_ready_b = 1'b1;
                    w_next_owner   = OWN_B;
                end
            end

            ST_ACCEPT: begin
                if (w_sel_valid) begin
                    w_load        = 1'b1;
                    w_next_update = 1'b1;
                    w_next_ptr_b  = ~r_grant_b;
                    if (HOLD_CYCLES == 0) begin
                        w_next_state = ST_IDLE;
                        w_next_owner = OWN_NONE;
                    end else begin
                        w_next_state    = ST_HOLD;
                        w_next_hold_cnt = HOLD_LOAD;
                    end
                end else begin
                    // Grantee withdrew before the handshake completed.
                    w_next_state = ST_IDLE;
                    w_next_owner = OWN_NONE;
                end
            end

            ST_HOLD: begin
                if (w_sel_valid) begin
                    w_next_state   = ST_ACCEPT;
                    w_next_ready_a = ~r_grant_b;
                    w_next_ready_b = r_grant_b;
                end else if (r_hold_cnt == '0) begin
                    w_next_state = ST_IDLE;
                    w_next_owner = OWN_NONE;
                end else begin
                    w_next_hold_cnt = r_hold_cnt - HOLD_WIDTH'(1);
                end
            end

            default: begin
                w_next_state = ST_IDLE;
                w_next_owner = OWN_NONE;
            end
        endcase
    end

    assign o_req_a_ready  = r_ready_a;
    assign o_req_b_ready  = r_ready_b;
    assign o_owner        = r_owner;
    assign o_frame_update = r_frame_update;
    assign o_display_D0   = r_disp_d0;
    assign o_display_D1   = r_disp_d1;
    assign o_display_D2   = r_disp_d2;
    assign o_display_D3   = r_disp_d3;

endmodule

// File: tb/tb_display_frame_arbiter.sv
// Testbench for display_frame_arbiter: directed scenarios followed by
// randomized requester traffic, every cycle compared against a
// transaction/time-stamp reference model.
module tb_display_frame_arbiter;

    localparam int HOLD   = 4;
    localparam int HOLD_W = 4;

    localparam logic [7:0] SEG_TAB [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        va, vb;
    logic [15:0] vala, valb;
    logic [3:0]  dotsa, dotsb;
    logic        rdy_a, rdy_b;
    logic [7:0]  d0, d1, d2, d3;
    logic [1:0]  owner;
    logic        upd;

    always #5 clk = ~clk;

    display_frame_arbiter #(
        .HOLD_CYCLES(HOLD),
        .HOLD_WIDTH (HOLD_W)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_req_a_valid (va),
        .i_req_a_value (vala),
        .i_req_a_dots  (dotsa),
        .o_req_a_ready (rdy_a),
        .i_req_b_valid (vb),
        .i_req_b_value (valb),
        .i_req_b_dots  (dotsb),
        .o_req_b_ready (rdy_b),
        .o_display_D0  (d0),
        .o_display_D1  (d1),
        .o_display_D2  (d2),
        .o_display_D3  (d3),
        .o_owner       (owner),
        .o_frame_update(upd)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: who holds a pending grant, who owns the display,
    // the tie-break preference and when the last frame landed.
    int         m_grant;      // 0 none, 1 A, 2 B: ready high this cycle
    int         m_owner;      // 0 none, 1 A, 2 B
    int         m_pref;       // 1 A, 2 B: wins a tie
    int         m_edge;
    int         m_last_load;
    logic       m_upd;
    logic [7:0] m_disp [4];

    function automatic logic [7:0] m_digit(input logic [15:0] v, input logic [3:0] dots, input int n);
        int         msd;
        logic [3:0] nib;
        logic [7:0] b;
        msd = 0;
        for (int i = 0; i < 4; i++) begin
            nib = v[4*i +: 4];
            if (nib != 4'h0) msd = i;
        end
        nib = v[4*n +: 4];
        b = SEG_TAB[nib];
`ifdef LEADING_ZERO_BLANK_EN
        if (n > msd) b = 8'h00;
`endif
        return b | {7'b0, dots[n]};
    endfunction

    task automatic model_reset();
        m_grant = 0;
        m_owner = 0;
        m_pref  = 1;
        m_upd   = 1'b0;
        for (int i = 0; i < 4; i++) m_disp[i] = 8'h00;
    endtask

    task automatic model_edge();
        logic        gv;
        logic [15:0] v;
        logic [3:0]  dt;
        m_edge++;
        m_upd = 1'b0;
        if (m_grant != 0) begin
            gv = (m_grant == 1) ? va : vb;
            if (gv) begin
                v  = (m_grant == 1) ? vala : valb;
                dt = (m_grant == 1) ? dotsa : dotsb;
                for (int i = 0; i < 4; i++) m_disp[i] = m_digit(v, dt, i);
                m_upd       = 1'b1;
                m_pref      = 3 - m_grant;
                m_last_load = m_edge;
                if (HOLD == 0) m_owner = 0;
            end else begin
                m_owner = 0;
            end
            m_grant = 0;
        end else if (m_owner != 0) begin
            if ((m_owner == 1) ? va : vb) m_grant = m_owner;
            else if (m_edge - m_last_load >= HOLD) m_owner = 0;
        end else begin
            if (va && vb) m_grant = m_pref;
            else if (va)  m_grant = 1;
            else if (vb)  m_grant = 2;
            m_owner = m_grant;
        end
    endtask

    task automatic step();
        logic [1:0] eo;
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else        model_edge();
        eo = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
        check("ready_a", {15'b0, rdy_a}, {15'b0, m_grant == 1});
        check("ready_b", {15'b0, rdy_b}, {15'b0, m_grant == 2});
        check("owner",   {14'b0, owner}, {14'b0, eo});
        check("update",  {15'b0, upd},   {15'b0, m_upd});
        check("D0", {8'b0, d0}, {8'b0, m_disp[0]});
        check("D1", {8'b0, d1}, {8'b0, m_disp[1]});
        check("D2", {8'b0, d2}, {8'b0, m_disp[2]});
        check("D3", {8'b0, d3}, {8'b0, m_disp[3]});
    endtask

    task automatic wait_free();
        for (int i = 0; i < 20 && owner != 2'b00; i++) step();
        check("wait_free", {14'b0, owner}, 16'h0);
    endtask

    task automatic wait_ready_a();
        for (int i = 0; i < 20 && !rdy_a; i++) step();
        check("wait_ready_a", {15'b0, rdy_a}, 16'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pra, prb;
        m_edge = 0;
        m_last_load = 0;
        model_reset();
        rst_n = 1'b0;
        va = 1'b0; vb = 1'b0;
        vala = '0; valb = '0; dotsa = '0; dotsb = '0;
        step(); step();
        check("rst_owner", {14'b0, owner}, 16'h0);
        check("rst_D0", {8'b0, d0}, 16'h0);
        check("rst_ready", {14'b0, rdy_a, rdy_b}, 16'h0);
        rst_n = 1'b1;
        step();

        // Single A frame: ready at N+1, display and pulse at N+2.
        va = 1'b1; vala = 16'h12AF; dotsa = 4'b0001;
        step();
        check("t1_ready_a", {15'b0, rdy_a}, 16'h1);
        check("t1_owner", {14'b0, owner}, 16'h1);
        step();
        va = 1'b0;
        check("t1_D3", {8'b0, d3}, 16'h60);
        check("t1_D2", {8'b0, d2}, 16'hDA);
        check("t1_D1", {8'b0, d1}, 16'hEE);
        check("t1_D0", {8'b0, d0}, 16'h8F);
        check("t1_update", {15'b0, upd}, 16'h1);
        step();
        check("t1_update_low", {15'b0, upd}, 16'h0);

        // Tie from reset: A first, B waits out the hold, then B wins the next tie.
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        va = 1'b1; vala = 16'h1111; dotsa = 4'h0;
        vb = 1'b1; valb = 16'h2222; dotsb = 4'h0;
        step();
        check("t2_first_a", {14'b0, rdy_a, rdy_b}, 16'h2);
        step();
        va = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_b_blocked", {15'b0, rdy_b}, 16'h0);
            check("t2_owner_hold", {14'b0, owner}, 16'h1);
        end
        step();
        check("t2_hold_over", {14'b0, owner}, 16'h0);
        va = 1'b1; vala = 16'h4567; dotsa = 4'h0;
        step();
        check("t2_tie_b", {14'b0, rdy_a, rdy_b}, 16'h1);
        check("t2_owner_b", {14'b0, owner}, 16'h2);
        step();
        vb = 1'b0;

        // Owner reload during hold bypasses the wait and restarts the window.
        step();
        check("t3_a_blocked", {15'b0, rdy_a}, 16'h0);
        vb = 1'b1; valb = 16'h0003; dotsb = 4'h0;
        step();
        check("t3_reload_ready", {15'b0, rdy_b}, 16'h1);
        step();
        vb = 1'b0;
        check("t3_D0", {8'b0, d0}, 16'hF2);
        check("t3_update", {15'b0, upd}, 16'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_restart", {14'b0, owner}, 16'h2);
        end
        step();
        step();
        check("t3_a_served", {15'b0, rdy_a}, 16'h1);
        step();
        va = 1'b0;

        // Grantee withdraws in ACCEPT: no update, display kept, tie pointer kept.
        wait_free();
        vb = 1'b1; valb = 16'hBEEF; dotsb = 4'hF;
        step();
        check("t4_ready_b", {15'b0, rdy_b}, 16'h1);
        vb = 1'b0;
        step();
        check("t4_no_update", {15'b0, upd}, 16'h0);
        check("t4_owner", {14'b0, owner}, 16'h0);
        check("t4_D3", {8'b0, d3}, 16'h66);
        check("t4_D0", {8'b0, d0}, 16'hE0);
        va = 1'b1; vala = 16'h0A0A; vb = 1'b1; valb = 16'hCAFE; dotsb = 4'h0;
        step();
        check("t4_ptr_kept", {14'b0, rdy_a, rdy_b}, 16'h1);
        step();
        vb = 1'b0;
        wait_ready_a();
        step();
        va = 1'b0;

        // Reset while ready is high.
        wait_free();
        va = 1'b1; vala = 16'h9876; dotsa = 4'h0;
        step();
        check("t5_ready", {15'b0, rdy_a}, 16'h1);
        rst_n = 1'b0;
        step();
        check("t5_ready_low", {14'b0, rdy_a, rdy_b}, 16'h0);
        check("t5_owner", {14'b0, owner}, 16'h0);
        check("t5_disp", {d1, d0}, 16'h0);
        check("t5_update", {15'b0, upd}, 16'h0);
        rst_n = 1'b1; va = 1'b0;
        step();

        // Leading-zero handling.
        va = 1'b1; vala = 16'h0050; dotsa = 4'h0;
        step(); step();
        va = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        check("t6_D3", {8'b0, d3}, 16'h00);
        check("t6_D2", {8'b0, d2}, 16'h00);
`else
        check("t6_D3", {8'b0, d3}, 16'hFC);
        check("t6_D2", {8'b0, d2}, 16'hFC);
`endif
        check("t6_D1", {8'b0, d1}, 16'hB6);
        check("t6_D0", {8'b0, d0}, 16'hFC);
        wait_free();

        // Randomized traffic from two well-behaved requesters with rare
        // withdrawals and occasional resets.
        for (int c = 0; c < 2000; c++) begin
            pra = rdy_a;
            prb = rdy_b;
            rst_n = ($urandom_range(0, 299) != 0);
            step();
            if (va && !pra) begin
                if ($urandom_range(0, 49) == 0) va = 1'b0;
            end else if ($urandom_range(0, 2) != 0) begin
                va = 1'b1; vala = 16'($urandom); dotsa = 4'($urandom);
            end else begin
                va = 1'b0;
            end
            if (vb && !prb) begin
                if ($urandom_range(0, 49) == 0) vb = 1'b0;
            end else if ($urandom_range(0, 2) != 0) begin
                vb = 1'b1; valb = 16'($urandom); dotsb = 4'($urandom);
            end else begin
                vb = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
